// File: rtl/or_flag_pkg.sv
`default_nettype none
// ============================================================
// or_flag_pkg : flag mode encoding and parameter limits
// Rev 1.0
// ============================================================
package or_flag_pkg;

  typedef enum logic [1:0] {
    LEVEL  = 2'd0,
    STICKY = 2'd1,
    RISE   = 2'd2,
    FALL   = 2'd3
  } mode_e;

  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 16;
  localparam int SOURCES_MIN  = 1;
  localparam int SOURCES_MAX  = 8;
  localparam int CNT_W_MIN    = 2;
  localparam int CNT_W_MAX    = 16;
  localparam int SEL_W        = 4;

endpackage : or_flag_pkg
`default_nettype wire

// File: rtl/or_flag_chan.sv
`default_nettype none
// ============================================================
// or_flag_chan : one channel - OR reduce, mode-selected flag,
//                saturating rising-edge counter
// Rev 1.0
// ============================================================
module or_flag_chan
  import or_flag_pkg::*;
#(
  parameter int SOURCES = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SOURCES-1:0] src,
  input  logic [1:0]         mode,
  input  logic               clr,
  output logic               flag,
  output logic [CNT_W-1:0]   count,
  output logic               sat
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             r_prev;
  logic             r_flag;
  logic [CNT_W-1:0] r_count;

  logic             w_or;
  logic             w_rise;
  logic             w_fall;
  logic             w_sat;
  logic             w_flag_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  mode_e            w_mode;

  assign w_or   = |src;
  assign w_rise = w_or & ~r_prev;
  assign w_fall = ~w_or & r_prev;
  assign w_sat  = (r_count == C_CNT_MAX);
  assign w_mode = mode_e'(mode);

  // STICKY: a live source outranks a same-cycle clear
  always_comb begin
    w_flag_nxt = r_flag;
    case (w_mode)
      LEVEL:   w_flag_nxt = w_or;
      STICKY: begin
        if (w_or)
          w_flag_nxt = 1'b1;
        else if (clr)
          w_flag_nxt = 1'b0;
      end
      RISE:    w_flag_nxt = w_rise;
      FALL:    w_flag_nxt = w_fall;
      default: w_flag_nxt = r_flag;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (clr)
      w_count_nxt = w_rise ? CNT_W'(1) : '0;
    else if (w_rise && !w_sat)
      w_count_nxt = r_count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev  <= 1'b0;
      r_flag  <= 1'b0;
      r_count <= '0;
    end else begin
      r_prev  <= w_or;
      r_flag  <= w_flag_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign flag  = r_flag;
  assign count = r_count;
  assign sat   = w_sat;

endmodule : or_flag_chan
`default_nettype wire

// File: rtl/or_flag_bank.sv
`default_nettype none
// ============================================================
// or_flag_bank : CHANNELS registered OR flags with per-channel
//                mode, event counters and counter readback
// Rev 1.0
// ============================================================
module or_flag_bank
  import or_flag_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SOURCES  = 2,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*SOURCES-1:0]  io_src,
  input  logic [2*CHANNELS-1:0]        io_mode,
  input  logic [CHANNELS-1:0]          io_clr,
  input  logic [SEL_W-1:0]             io_sel,
  output logic [CHANNELS-1:0]          io_s,
  output logic                         io_any,
  output logic [CNT_W-1:0]             io_count,
  output logic [CHANNELS-1:0]          io_sat
);

  logic [CNT_W-1:0] w_cnt [CHANNELS];
  logic [CNT_W-1:0] w_count;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    or_flag_chan #(
      .SOURCES (SOURCES),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .src   (io_src[c*SOURCES +: SOURCES]),
      .mode  (io_mode[2*c +: 2]),
      .clr   (io_clr[c]),
      .flag  (io_s[c]),
      .count (w_cnt[c]),
      .sat   (io_sat[c])
    );
  end

  assign io_any = |io_s;

  // Unpopulated select values fall through to zero
  always_comb begin
    w_count = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (io_sel == SEL_W'(c))
        w_count = w_cnt[c];
    end
  end

  assign io_count = w_count;

endmodule : or_flag_bank
`default_nettype wire

// File: tb/tb_or_flag_bank.sv
`default_nettype none
// ============================================================
// tb_or_flag_bank : directed + randomized bench with behavioural
//                   model, two instances (CNT_W = 8 and 2)
// Rev 1.0
// ============================================================
`timescale 1ns/1ps
module tb_or_flag_bank;

  localparam int CH   = 4;
  localparam int SRC  = 2;
  localparam int CW1  = 8;
  localparam int CW2  = 2;
  localparam int MAX1 = (1 << CW1) - 1;
  localparam int MAX2 = (1 << CW2) - 1;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic [CH*SRC-1:0] io_src  = '0;
  logic [2*CH-1:0]   io_mode = '0;
  logic [CH-1:0]     io_clr  = '0;
  logic [3:0]        io_sel  = '0;

  logic [CH-1:0]  s1, sat1, s2, sat2;
  logic           any1, any2;
  logic [CW1-1:0] cnt1;
  logic [CW2-1:0] cnt2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  or_flag_bank #(.CHANNELS(CH), .SOURCES(SRC), .CNT_W(CW1)) dut (
    .clk(clk), .reset(reset), .io_src(io_src), .io_mode(io_mode),
    .io_clr(io_clr), .io_sel(io_sel), .io_s(s1), .io_any(any1),
    .io_count(cnt1), .io_sat(sat1)
  );

  or_flag_bank #(.CHANNELS(CH), .SOURCES(SRC), .CNT_W(CW2)) dut2 (
    .clk(clk), .reset(reset), .io_src(io_src), .io_mode(io_mode),
    .io_clr(io_clr), .io_sel(io_sel), .io_s(s2), .io_any(any2),
    .io_count(cnt2), .io_sat(sat2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: previous OR value, flag and two counter views
  bit m_prev [CH];
  bit m_flag [CH];
  int m_cnt1 [CH];
  int m_cnt2 [CH];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        m_prev[c] = 0; m_flag[c] = 0; m_cnt1[c] = 0; m_cnt2[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit o, r, f;
        int md;
        o  = |io_src[c*SRC +: SRC];
        md = int'(io_mode[2*c +: 2]);
        r  = o && !m_prev[c];
        f  = !o && m_prev[c];
        case (md)
          0: m_flag[c] = o;
          1: if (o) m_flag[c] = 1; else if (io_clr[c]) m_flag[c] = 0;
          2: m_flag[c] = r;
          default: m_flag[c] = f;
        endcase
        if (io_clr[c]) begin
          m_cnt1[c] = r ? 1 : 0;
          m_cnt2[c] = r ? 1 : 0;
        end else if (r) begin
          if (m_cnt1[c] < MAX1) m_cnt1[c] = m_cnt1[c] + 1;
          if (m_cnt2[c] < MAX2) m_cnt2[c] = m_cnt2[c] + 1;
        end
        m_prev[c] = o;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CH-1:0] es, esat1, esat2;
      int e1, e2;
      for (int c = 0; c < CH; c++) begin
        es[c]    = m_flag[c];
        esat1[c] = (m_cnt1[c] == MAX1);
        esat2[c] = (m_cnt2[c] == MAX2);
      end
      e1 = 0; e2 = 0;
      if (int'(io_sel) < CH) begin
        e1 = m_cnt1[io_sel];
        e2 = m_cnt2[io_sel];
      end
      check("io_s",      s1,   es);
      check("io_any",    any1, |es);
      check("io_count",  cnt1, e1);
      check("io_sat",    sat1, esat1);
      check("io_s2",     s2,   es);
      check("io_any2",   any2, |es);
      check("io_count2", cnt2, e2);
      check("io_sat2",   sat2, esat2);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #3;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset with all sources high, LEVEL mode
    #1 reset = 1'b0;
    chk_en = 1'b1;
    io_src = '1;
    #1;
    check("rst_s",   s1,   0);
    check("rst_any", any1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_sat", sat1, 0);
    tick();
    reset = 1'b1;
    tick();
    check("rel_s",    s1,   4'hF);
    check("rel_cnt",  cnt1, 1);
    check("rel_cnt2", cnt2, 1);

    // Channel 1 STICKY
    io_src  = '0;
    io_mode = 8'b00_00_01_00;
    tick(2);
    io_src[3] = 1'b1;
    tick();
    check("sticky_set", s1[1], 1);
    io_src = '0;
    tick(20);
    check("sticky_hold", s1[1], 1);
    io_clr[1] = 1'b1;
    tick();
    check("sticky_clr", s1[1], 0);
    io_src[3] = 1'b1;
    tick();
    check("sticky_set_wins", s1[1], 1);
    io_clr = '0;
    io_src = '0;

    // Channel 2 RISE then FALL
    io_mode = 8'b00_10_00_00;
    tick(2);
    io_src[4] = 1'b1;
    tick();
    check("rise_pulse", s1[2], 1);
    tick();
    check("rise_once", s1[2], 0);
    tick(3);
    io_src[4] = 1'b0;
    tick();
    check("rise_no_fall", s1[2], 0);
    io_mode = 8'b00_11_00_00;
    io_src[4] = 1'b1;
    tick(5);
    check("fall_quiet_high", s1[2], 0);
    io_src[4] = 1'b0;
    tick();
    check("fall_pulse", s1[2], 1);
    tick();
    check("fall_once", s1[2], 0);

    // Saturation on the 2-bit counter, channel 0
    io_mode = '0;
    io_src  = '0;
    io_sel  = 4'd0;
    io_clr[0] = 1'b1;
    tick();
    io_clr = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      io_src[0] = 1'b1;
      tick();
      check("sat_cnt", cnt2, sat_exp[i]);
      check("sat_flag", sat2[0], (i >= 2) ? 1 : 0);
      io_src[0] = 1'b0;
      tick();
    end
    io_src[0] = 1'b1;
    io_clr[0] = 1'b1;
    tick();
    check("clr_rise", cnt2, 1);
    io_clr = '0;
    io_src = '0;

    // Out-of-range select and io_any
    io_sel = 4'd4;
    #1;
    check("sel_oob",  cnt1, 0);
    check("sel_oob2", cnt2, 0);
    tick(2);
    check("any_none", any1, 0);
    io_src[6] = 1'b1;
    tick();
    check("any_one", any1, 1);

    // Channel 3 STICKY with count 7, then asynchronous reset
    io_mode = 8'b01_00_00_00;
    io_src  = '0;
    io_clr[3] = 1'b1;
    tick();
    io_clr = '0;
    for (int i = 0; i < 7; i++) begin
      io_src[6] = 1'b1;
      tick();
      io_src[6] = 1'b0;
      tick();
    end
    io_sel = 4'd3;
    #1;
    check("cnt7",    cnt1,  7);
    check("sticky3", s1[3], 1);
    reset = 1'b0;
    #1;
    check("async_rst_s",   s1,   0);
    check("async_rst_cnt", cnt1, 0);
    tick();
    reset = 1'b1;

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) io_src = CH*SRC'($urandom);
      if ($urandom_range(0, 15) == 0) io_mode = 2*CH'($urandom);
      for (int c = 0; c < CH; c++) io_clr[c] = ($urandom_range(0, 7) == 0);
      io_sel = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      reset  = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_or_flag_bank
`default_nettype wire
